// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and constants for the RV32I integer register file.
package regfile_pkg;
    localparam int REG_NUM     = 32;
    localparam int RADDR_WIDTH = 5;
    localparam int RDATA_WIDTH = 32;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;
    localparam logic [RDATA_WIDTH-1:0] ZERO     = '0;
endpackage

// File: rtl/regfile_rport.sv
// regfile_rport: combinational read mux with WB-to-ID write-through bypass.
module regfile_rport
    import regfile_pkg::*;
#(
    parameter int AW = RADDR_WIDTH,
    parameter int DW = RDATA_WIDTH
) (
    input  logic          rst_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [DW-1:0] stored_i,
    output logic [DW-1:0] rdata_o
);
    always_comb begin
        rdata_o = (rst_i || re_i == READ_DISABLE || raddr_i == '0) ? '0 :
                  (we_i == WRITE_ENABLE && waddr_i == raddr_i)    ? wdata_i : stored_i;
    end
endmodule

// File: rtl/regfile.sv
// regfile: 32 x 32 integer register file, two bypassed read ports, one write port,
// a raw debug read port and a committed-write counter.
module regfile
    import regfile_pkg::*;
#(
    parameter int REG_NUM_P = REG_NUM,
    parameter int AW        = RADDR_WIDTH,
    parameter int DW        = RDATA_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] reg1_raddr_i,
    input  logic          reg1_re_i,
    output logic [DW-1:0] reg1_rdata_o,
    input  logic [AW-1:0] reg2_raddr_i,
    input  logic          reg2_re_i,
    output logic [DW-1:0] reg2_rdata_o,
    input  logic          reg_we_i,
    input  logic [AW-1:0] reg_waddr_i,
    input  logic [DW-1:0] reg_wdata_i,
    input  logic [AW-1:0] dbg_raddr_i,
    output logic [DW-1:0] dbg_rdata_o,
    output logic [31:0]   wr_cnt_o
);
    logic [DW-1:0] regs_q [REG_NUM_P];
    logic [DW-1:0] regs_d [REG_NUM_P];
    logic [31:0]   wr_cnt_q, wr_cnt_d;
    logic          commit;

    always_comb begin
        commit   = reg_we_i == WRITE_ENABLE && reg_waddr_i != '0;
        regs_d   = regs_q;
        wr_cnt_d = commit ? wr_cnt_q + 32'd1 : wr_cnt_q;
        if (commit) regs_d[reg_waddr_i] = reg_wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q   <= '{default: '0};
            wr_cnt_q <= '0;
        end else begin
            regs_q   <= regs_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    regfile_rport #(.AW(AW), .DW(DW)) u_rport1 (
        .rst_i(rst_i), .re_i(reg1_re_i), .raddr_i(reg1_raddr_i),
        .we_i(reg_we_i), .waddr_i(reg_waddr_i), .wdata_i(reg_wdata_i),
        .stored_i(regs_q[reg1_raddr_i]), .rdata_o(reg1_rdata_o)
    );

    regfile_rport #(.AW(AW), .DW(DW)) u_rport2 (
        .rst_i(rst_i), .re_i(reg2_re_i), .raddr_i(reg2_raddr_i),
        .we_i(reg_we_i), .waddr_i(reg_waddr_i), .wdata_i(reg_wdata_i),
        .stored_i(regs_q[reg2_raddr_i]), .rdata_o(reg2_rdata_o)
    );

    assign dbg_rdata_o = (rst_i || dbg_raddr_i == '0) ? '0 : regs_q[dbg_raddr_i];
    assign wr_cnt_o    = wr_cnt_q;
endmodule
